wb_fuzz_arbiter: RTL and testbench
==================================

Name: wb_fuzz_arbiter

Overview:
- Shares one Wishbone slave IP (e.g. sha256_top) among NUM_MASTERS fuzz masters: random fuzzer, mutated fuzzer, replay master.
- Round-robin grant, time-slice preemption at transfer boundaries, per-transfer watchdog with bus abort.
- Sits between the fuzzer instances and the IP inside the satellite fuzzer wrapper.
- Timeout events and counts feed the wrapper status/report logic.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..4)
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; select width is DATA_WIDTH/8
SLICE_CYCLES, 64, grant quantum in cycles before preemption is allowed
TIMEOUT_CYCLES, 100, cycles stb may wait for ack/err before abort

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_enable  in  NUM_MASTERS  per-master enable mask
m_cyc  in  NUM_MASTERS  master cycle requests
m_stb  in  NUM_MASTERS  master strobes
m_we  in  NUM_MASTERS  master write enables
m_adr  in  NUM_MASTERS*ADDR_WIDTH  packed master addresses, master i at [i*AW +: AW]
m_wdat  in  NUM_MASTERS*DATA_WIDTH  packed master write data
m_sel  in  NUM_MASTERS*DATA_WIDTH/8  packed master byte selects
m_ack  out  NUM_MASTERS  ack routed to grantee only
m_err  out  NUM_MASTERS  err routed to grantee, or abort error
m_rdat  out  DATA_WIDTH  slave read data, valid only with m_ack
s_cyc, s_stb, s_we  out  1 each  slave bus controls
s_adr  out  ADDR_WIDTH  slave address
s_wdat  out  DATA_WIDTH  slave write data
s_sel  out  DATA_WIDTH/8  slave byte select
s_ack, s_err  in  1 each  slave responses
s_rdat  in  DATA_WIDTH  slave read data
grant  out  NUM_MASTERS  one-hot current grant, or all zero
timeout_pulse  out  1  one-cycle pulse on abort
timeout_count  out  8  saturating abort count
timeout_master  out  $clog2(NUM_MASTERS)  index of last aborted master

Behaviour:
Reset:
- state=IDLE, grant=0, last_grant=NUM_MASTERS-1, so master 0 wins first.
- All s_* outputs, m_ack, m_err, m_rdat, timeout_pulse, timeout_count and timeout_master are 0.
- Reset mid-transfer drops s_cyc immediately; no ack or err is delivered.

Request and bus mux:
- A request is m_cyc[i] & cfg_enable[i].
- With no grant, s_* are held 0.
- With a grant, s_* = grantee signals, combinationally from the registered grant.
- m_ack[g] = s_ack and m_err[g] = s_err; all non-grantees see 0.
- m_rdat = s_rdat when grant is nonzero, else 0.

IDLE:
- If any request exists, select the first requester searching from last_grant+1 with wrap-around.
- Register the grant and move to GRANT.
- Latency: m_cyc rising at cycle t → s_cyc at t+1.

GRANT:
- slice_cnt increments each cycle and saturates at SLICE_CYCLES.
- Release when grantee m_cyc=0: grant→0, last_grant=g, state→IDLE. Re-arbitration happens the next cycle, so there is one idle cycle between owners.
- Preempt when slice_cnt==SLICE_CYCLES, another request is pending, and grantee m_stb=0 (transfer boundary). Release as above. The preempted master keeps cyc high and stalls until re-granted.
- Disable: cfg_enable[g] falling is handled like preemption at the next stb=0 boundary, regardless of the slice count.
- Watchdog: wd_cnt counts cycles with s_stb=1 & !s_ack & !s_err and clears on ack/err or stb low.
  - Reaching TIMEOUT_CYCLES → ABORT.
  - If ack or err arrives in the same cycle the threshold is reached, the response wins and no abort occurs.

ABORT (one cycle):
- s_cyc=s_stb=0.
- m_err[g]=1 for exactly this cycle.
- timeout_pulse=1.
- timeout_count +1, saturating at 255.
- timeout_master=g.
- Next state IDLE with last_grant=g.

Invariants:
- grant is always one-hot or zero.
- A master never sees ack/err while ungranted.
- A single-requester master is never preempted.

Decomposition:
- Shared package fuzz_pkg: typedef arb_state_e {IDLE, GRANT, ABORT}, and the ABORT status code constant 32'hA807_0000 for wrapper status use.
- One sub-module rr_pick: combinational round-robin priority picker. Inputs are the req vector and last index; outputs are the one-hot grant and its index.
- Counters and FSM stay in wb_fuzz_arbiter.

Test Plan:
1. Reset, then m_cyc[0] with a write to adr 0x10, data 0xA5A5A5A5, slave acks after 2 cycles → s_cyc high at t+1, s_adr=0x10, m_ack[0] single pulse, grant=01, then 00 after cyc drops.
2. Both masters assert cyc in the same cycle → master 0 granted first; master 1 granted after master 0 drops cyc plus one idle cycle; when both request again, master 1 wins.
3. Master 0 holds cyc for 200 cycles with stb toggling, master 1 requesting, SLICE_CYCLES=64 → grant moves to master 1 at the first stb=0 cycle after 64 cycles; master 0 sees no ack while ungranted.
4. Slave never acks, TIMEOUT_CYCLES=100 → ABORT at stb cycle 100: m_err[g] one cycle, timeout_pulse once, timeout_count=1, timeout_master=g, s_cyc=0; repeat 300 times → timeout_count saturates at 255.
5. s_ack on the same cycle the watchdog reaches 100 → m_ack delivered, no m_err, timeout_count unchanged.
6. cfg_enable[1] cleared mid-burst, then rst_n asserted mid-transfer → master 1 released at its next stb=0 cycle and never re-granted; after reset all outputs are 0 and master 0 is granted first.

Source files
------------

// File: rtl/fuzz_pkg.sv
// Shared types and constants for the satellite fuzzer wrapper.
// The abort status code is consumed by the wrapper's status/report logic.
package fuzz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic [31:0] ABORT_STATUS = 32'hA807_0000;

endpackage

// File: rtl/wb_fuzz_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx, with wrap.
// pick_valid is low when no request is present; the other outputs are then zero.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  pick_onehot,
  output logic [IW-1:0] pick_idx,
  output logic          pick_valid
);

  always_comb begin : pick
    logic [IW-1:0] cand;
    cand        = '0;
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_idx) + k) % N);
      if (!pick_valid && req[cand]) begin
        pick_valid        = 1'b1;
        pick_onehot[cand] = 1'b1;
        pick_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/wb_fuzz_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave IP among fuzz masters, with
// time-slice preemption at transfer boundaries and a per-transfer watchdog abort.
module wb_fuzz_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLICE_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_MASTERS-1:0]                cfg_enable,
  input  logic [NUM_MASTERS-1:0]                m_cyc,
  input  logic [NUM_MASTERS-1:0]                m_stb,
  input  logic [NUM_MASTERS-1:0]                m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdat,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel,
  output logic [NUM_MASTERS-1:0]                m_ack,
  output logic [NUM_MASTERS-1:0]                m_err,
  output logic [DATA_WIDTH-1:0]                 m_rdat,
  output logic                                  s_cyc,
  output logic                                  s_stb,
  output logic                                  s_we,
  output logic [ADDR_WIDTH-1:0]                 s_adr,
  output logic [DATA_WIDTH-1:0]                 s_wdat,
  output logic [DATA_WIDTH/8-1:0]               s_sel,
  input  logic                                  s_ack,
  input  logic                                  s_err,
  input  logic [DATA_WIDTH-1:0]                 s_rdat,
  output logic [NUM_MASTERS-1:0]                grant,
  output logic                                  timeout_pulse,
  output logic [7:0]                            timeout_count,
  output logic [$clog2(NUM_MASTERS)-1:0]        timeout_master,
  output logic [1:0]                            dbg_state
);
  import fuzz_pkg::*;

  // Handshake: a master transfer is in flight while its cyc&stb are high and it
  // owns the grant; it completes in the cycle s_ack or s_err is seen high.
  localparam int IW   = $clog2(NUM_MASTERS);
  localparam int SELW = DATA_WIDTH / 8;
  localparam int SW   = $clog2(SLICE_CYCLES + 1);
  localparam int WW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SLICE_MAX  = SW'(SLICE_CYCLES);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RESET = IW'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [SW-1:0]          slice_q, slice_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic [7:0]             tcount_q, tcount_d;
  logic [IW-1:0]          tmaster_q, tmaster_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   g_cyc, g_stb, wd_wait, other_req, release_now;

  logic [ADDR_WIDTH-1:0]  adr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  wdat_arr [NUM_MASTERS];
  logic [SELW-1:0]        sel_arr  [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign adr_arr[i]  = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdat_arr[i] = m_wdat[i*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[i]  = m_sel[i*SELW +: SELW];
  end

  assign req = m_cyc & cfg_enable;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req         (req),
    .last_idx    (last_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  assign g_cyc     = m_cyc[gidx_q];
  assign g_stb     = m_stb[gidx_q];
  assign other_req = |(req & ~grant_q);

  // Bus mux: the slave only ever sees the registered grantee, and only in GRANT.
  always_comb begin
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    s_we   = 1'b0;
    s_adr  = '0;
    s_wdat = '0;
    s_sel  = '0;
    m_ack  = '0;
    m_err  = '0;
    if (state_q == GRANT) begin
      s_cyc  = g_cyc;
      s_stb  = g_stb;
      s_we   = m_we[gidx_q];
      s_adr  = adr_arr[gidx_q];
      s_wdat = wdat_arr[gidx_q];
      s_sel  = sel_arr[gidx_q];
      m_ack  = grant_q & {NUM_MASTERS{s_ack}};
      m_err  = grant_q & {NUM_MASTERS{s_err}};
    end else if (state_q == ABORT) begin
      m_err  = grant_q;
    end
  end

  assign m_rdat         = (|grant_q) ? s_rdat : '0;
  assign grant          = grant_q;
  assign timeout_pulse  = (state_q == ABORT);
  assign timeout_count  = tcount_q;
  assign timeout_master = tmaster_q;
  assign dbg_state      = state_q;

  assign wd_wait = s_stb & ~s_ack & ~s_err;

  // Voluntary drop, slice expiry or a disabled grantee all hand over only
  // between transfers (stb low), so no in-flight beat is ever cut.
  assign release_now = !g_cyc ||
                       (!g_stb && ((slice_q == SLICE_MAX && other_req) || !cfg_enable[gidx_q]));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    slice_d   = slice_q;
    wd_d      = wd_q;
    tcount_d  = tcount_q;
    tmaster_d = tmaster_q;
    unique case (state_q)
      IDLE: begin
        slice_d = '0;
        wd_d    = '0;
        if (pick_valid) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        slice_d = (slice_q == SLICE_MAX) ? slice_q : slice_q + 1'b1;
        wd_d    = wd_wait ? wd_q + 1'b1 : '0;
        if (g_cyc && wd_wait && wd_q == WD_LAST) begin
          state_d   = ABORT;
          wd_d      = '0;
          tcount_d  = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
          tmaster_d = gidx_q;
        end else if (release_now) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = gidx_q;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= LAST_RESET;
      slice_q   <= '0;
      wd_q      <= '0;
      tcount_q  <= '0;
      tmaster_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      slice_q   <= slice_d;
      wd_q      <= wd_d;
      tcount_q  <= tcount_d;
      tmaster_q <= tmaster_d;
    end
  end

endmodule

// File: tb/tb_wb_fuzz_arbiter.sv
// Directed bench for wb_fuzz_arbiter: two masters, 64-cycle slice, 100-cycle watchdog.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_wb_fuzz_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_enable, m_cyc, m_stb, m_we, m_ack, m_err, grant;
  logic [63:0] m_adr, m_wdat;
  logic [7:0]  m_sel;
  logic [31:0] m_rdat, s_adr, s_wdat, s_rdat;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, timeout_pulse;
  logic [3:0]  s_sel;
  logic [7:0]  timeout_count;
  logic        timeout_master;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_fuzz_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SLICE_CYCLES(64), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_wdat(m_wdat), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_rdat(m_rdat),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_wdat(s_wdat), .s_sel(s_sel),
    .s_ack(s_ack), .s_err(s_err), .s_rdat(s_rdat),
    .grant(grant), .timeout_pulse(timeout_pulse), .timeout_count(timeout_count),
    .timeout_master(timeout_master), .dbg_state(dbg_state)
  );

  task automatic nstep();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cfg_enable = 2'b11; m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_wdat = '0; m_sel = '0; s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
  endtask

  // Returns at a falling edge with reset just released and idle inputs.
  task automatic do_reset();
    idle_inputs();
    nstep(); rst_n = 1'b0;
    nstep(); nstep(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1; s_err = 1'b1; s_rdat = 32'hDEAD_BEEF;
    nstep(); nstep(); #1;
    total_cnt++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else pass_cnt++;
    total_cnt++; if ({s_cyc, s_stb, s_we} !== 3'b000) $display("FAIL rst_s_ctl: got %b want 000", {s_cyc, s_stb, s_we}); else pass_cnt++;
    total_cnt++; if ({m_ack, m_err} !== 4'b0000) $display("FAIL rst_m_resp: got %b want 0000", {m_ack, m_err}); else pass_cnt++;
    total_cnt++; if (m_rdat !== 32'h0) $display("FAIL rst_m_rdat: got %h want 0", m_rdat); else pass_cnt++;
    total_cnt++; if ({timeout_pulse, timeout_count, timeout_master} !== 10'h0) $display("FAIL rst_timeout: got %b/%0d/%b want 0/0/0", timeout_pulse, timeout_count, timeout_master); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_adr[31:0] = 32'h10; m_wdat[31:0] = 32'hA5A5_A5A5; m_sel[3:0] = 4'hF;
    #1;
    total_cnt++; if (s_cyc !== 1'b0) $display("FAIL wr_s_cyc_t0: got %b want 0", s_cyc); else pass_cnt++;
    nstep(); #1;
    total_cnt++; if (s_cyc !== 1'b1) $display("FAIL wr_s_cyc_t1: got %b want 1", s_cyc); else pass_cnt++;
    total_cnt++; if (grant !== 2'b01) $display("FAIL wr_grant: got %b want 01", grant); else pass_cnt++;
    total_cnt++; if ({s_stb, s_we, s_adr, s_wdat, s_sel} !== {1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF})
      $display("FAIL wr_s_bus: got stb=%b we=%b adr=%h wdat=%h sel=%h want 1 1 10 a5a5a5a5 f", s_stb, s_we, s_adr, s_wdat, s_sel); else pass_cnt++;
    total_cnt++; if (m_ack !== 2'b00) $display("FAIL wr_ack_early: got %b want 00", m_ack); else pass_cnt++;
    nstep(); s_ack = 1'b1; s_rdat = 32'h0000_1234; #1;
    total_cnt++; if (m_ack !== 2'b01) $display("FAIL wr_ack: got %b want 01", m_ack); else pass_cnt++;
    total_cnt++; if (m_rdat !== 32'h0000_1234) $display("FAIL wr_rdat: got %h want 00001234", m_rdat); else pass_cnt++;
    nstep(); s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; #1;
    total_cnt++; if ({m_ack, s_cyc} !== 3'b000) $display("FAIL wr_ack_pulse: got ack=%b s_cyc=%b want 00 0", m_ack, s_cyc); else pass_cnt++;
    nstep(); #1;
    total_cnt++; if (grant !== 2'b00) $display("FAIL wr_release: got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    m_cyc = 2'b11; #1;
    nstep(); m_cyc = 2'b10; #1;
    total_cnt++; if (grant !== 2'b01) $display("FAIL rr_first: got %b want 01", grant); else pass_cnt++;
    nstep(); m_cyc = 2'b11; #1;
    total_cnt++; if (grant !== 2'b00) $display("FAIL rr_idle_gap: got %b want 00", grant); else pass_cnt++;
    nstep(); m_cyc = 2'b01; #1;
    total_cnt++; if (grant !== 2'b10) $display("FAIL rr_second: got %b want 10", grant); else pass_cnt++;
    nstep(); #1;
    total_cnt++; if (grant !== 2'b00) $display("FAIL rr_idle_gap2: got %b want 00", grant); else pass_cnt++;
    nstep(); #1;
    total_cnt++; if (grant !== 2'b01) $display("FAIL rr_third: got %b want 01", grant); else pass_cnt++;
    m_cyc = '0;
    nstep(); nstep();
  endtask

  // Master 0 strobes every even cycle, master 1 waits with cyc high, slave always acks.
  // Slice hits 64 at cycle 65 (stb low) -> idle at 66 -> master 1 owns from 67.
  task automatic test_preempt();
    logic [1:0] exp_g;
    do_reset();
    s_ack = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) nstep();
      m_cyc = 2'b11;
      m_stb = {1'b0, (k % 2 == 0)};
      #1;
      if (k == 0)       exp_g = 2'b00;
      else if (k < 66)  exp_g = 2'b01;
      else if (k == 66) exp_g = 2'b00;
      else              exp_g = 2'b10;
      total_cnt++; if (grant !== exp_g) $display("FAIL pre_grant[%0d]: got %b want %b", k, grant, exp_g); else pass_cnt++;
      total_cnt++; if (m_ack !== exp_g) $display("FAIL pre_ack[%0d]: got %b want %b", k, m_ack, exp_g); else pass_cnt++;
    end
    idle_inputs();
    nstep(); nstep();
  endtask

  task automatic test_timeout();
    int seen;
    bit found;
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    for (int k = 1; k <= 102; k++) begin
      nstep(); #1;
      if (k == 100) begin
        total_cnt++; if ({timeout_pulse, m_err} !== 3'b000) $display("FAIL to_early: got pulse=%b err=%b want 0 00", timeout_pulse, m_err); else pass_cnt++;
      end else if (k == 101) begin
        total_cnt++; if (timeout_pulse !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout_pulse); else pass_cnt++;
        total_cnt++; if (m_err !== 2'b10) $display("FAIL to_err: got %b want 10", m_err); else pass_cnt++;
        total_cnt++; if ({s_cyc, s_stb} !== 2'b00) $display("FAIL to_s_cyc: got %b want 00", {s_cyc, s_stb}); else pass_cnt++;
        total_cnt++; if (timeout_master !== 1'b1) $display("FAIL to_master: got %b want 1", timeout_master); else pass_cnt++;
        total_cnt++; if (timeout_count !== 8'd1) $display("FAIL to_count1: got %0d want 1", timeout_count); else pass_cnt++;
        total_cnt++; if (dbg_state !== 2'd2) $display("FAIL to_state: got %0d want 2", dbg_state); else pass_cnt++;
      end else if (k == 102) begin
        total_cnt++; if ({timeout_pulse, m_err, grant} !== 5'b0) $display("FAIL to_after: got pulse=%b err=%b grant=%b want 0", timeout_pulse, m_err, grant); else pass_cnt++;
      end
    end
    seen = 1;
    for (int a = 2; a <= 300; a++) begin
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
        nstep(); #1;
        if (timeout_pulse === 1'b1) found = 1'b1;
      end
      if (!found) begin
        total_cnt++;
        $display("FAIL to_wait: abort %0d not seen within 200 cycles, got 0 want 1", a);
        break;
      end
      seen++;
      if (a == 10) begin
        total_cnt++; if (timeout_count !== 8'd10) $display("FAIL to_count10: got %0d want 10", timeout_count); else pass_cnt++;
      end
    end
    total_cnt++; if (seen !== 300) $display("FAIL to_seen: got %0d want 300", seen); else pass_cnt++;
    total_cnt++; if (timeout_count !== 8'd255) $display("FAIL to_saturate: got %0d want 255", timeout_count); else pass_cnt++;
    idle_inputs();
    nstep(); nstep();
  endtask

  task automatic test_ack_at_threshold();
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01;
    for (int k = 1; k < 100; k++) nstep();
    nstep(); s_ack = 1'b1; #1;
    total_cnt++; if ({m_ack, m_err} !== 4'b0100) $display("FAIL thr_ack: got ack=%b err=%b want 01 00", m_ack, m_err); else pass_cnt++;
    nstep(); s_ack = 1'b0; m_cyc = '0; m_stb = '0; #1;
    total_cnt++; if ({timeout_pulse, m_err} !== 3'b000) $display("FAIL thr_no_abort: got pulse=%b err=%b want 0 00", timeout_pulse, m_err); else pass_cnt++;
    nstep(); #1;
    total_cnt++; if (timeout_count !== 8'd0) $display("FAIL thr_count: got %0d want 0", timeout_count); else pass_cnt++;
    total_cnt++; if (grant !== 2'b00) $display("FAIL thr_release: got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_disable_reset();
    logic [1:0] exp_g;
    do_reset();
    s_ack = 1'b1;
    m_cyc = 2'b10; m_stb = 2'b10;
    for (int k = 1; k <= 9; k++) begin
      nstep();
      if (k == 2) cfg_enable = 2'b01;
      m_stb = (k <= 3) ? 2'b10 : ((k % 2 == 0) ? 2'b00 : 2'b10);
      #1;
      exp_g = (k <= 4) ? 2'b10 : 2'b00;
      total_cnt++; if (grant !== exp_g) $display("FAIL dis_grant[%0d]: got %b want %b", k, grant, exp_g); else pass_cnt++;
    end
    nstep(); m_cyc = 2'b11; m_stb = 2'b00;
    nstep(); #1;
    total_cnt++; if (grant !== 2'b01) $display("FAIL dis_m0: got %b want 01", grant); else pass_cnt++;
    nstep(); m_stb = 2'b01; rst_n = 1'b0; #1;
    total_cnt++; if ({grant, s_cyc, s_stb, m_ack, m_err} !== 8'b0) $display("FAIL dis_rst: got grant=%b s_cyc=%b s_stb=%b ack=%b err=%b want 0", grant, s_cyc, s_stb, m_ack, m_err); else pass_cnt++;
    nstep(); rst_n = 1'b1; cfg_enable = 2'b11; m_stb = 2'b00; s_ack = 1'b0; #1;
    total_cnt++; if ({grant, timeout_count} !== 10'b0) $display("FAIL dis_post_rst: got grant=%b count=%0d want 0", grant, timeout_count); else pass_cnt++;
    nstep(); #1;
    total_cnt++; if (grant !== 2'b01) $display("FAIL dis_first: got %b want 01", grant); else pass_cnt++;
    idle_inputs();
    nstep(); nstep();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_preempt();
    test_timeout();
    test_ack_at_threshold();
    test_disable_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL sim_time_limit: got no end of test, want completion before 5ms");
    $fatal(1, "time limit");
  end

endmodule
